// File: rtl/count_input_conditioner_pkg.sv
// count_input_conditioner_pkg
// Shared defaults, the inc-channel FSM state type and small sizing helpers
// used by the count input conditioner and its debouncer sub-module.
package count_input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int REPEAT_DELAY_DEF    = 64;
  localparam int REPEAT_PERIOD_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } inc_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold the value n itself (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer
// Two-flop synchronizer followed by a run-length debouncer for one button.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-high reset
//   raw   - asynchronous button input
//   sync  - synchronized button level
//   level - debounced level
//   flip  - high in the cycle whose rising edge will toggle level
module input_debouncer
  import count_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic level,
  output logic flip
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          meta;
  logic [CW-1:0] run;
  logic          differ;

  // The run counter reaches DEBOUNCE_CYCLES before the flip is taken, which
  // makes the total latency from raw sampling to level change 2+DEBOUNCE_CYCLES.
  assign differ = sync ^ level;
  assign flip   = differ && (run == CW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      run   <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (!differ) begin
        run <= '0;
      end else if (flip) begin
        level <= ~level;
        run   <= '0;
      end else begin
        run <= run + CW'(1);
      end
    end
  end

endmodule

// File: rtl/count_input_conditioner.sv
// count_input_conditioner
// Turns two raw buttons into clean strobes for a downstream counter: a
// debounced increment with auto-repeat, and a debounced load with captured
// data. Load has priority; a colliding increment is delivered one cycle late.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   ena        - enable; low forces both strobes to 0 and idles the FSM
//   raw_inc    - asynchronous increment button
//   raw_load   - asynchronous load button
//   load_value - value captured when a load is accepted
//   inc_pulse  - one-cycle increment strobe
//   load_pulse - one-cycle load strobe
//   load_data  - last captured load value
module count_input_conditioner
  import count_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       raw_inc,
  input  logic       raw_load,
  input  logic [7:0] load_value,
  output logic       inc_pulse,
  output logic       load_pulse,
  output logic [7:0] load_data
);

  localparam int TW         = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  // A channel is armed only after its synchronized input has been seen low
  // long enough to cover synchronizer warm-up, so a button held through
  // reset cannot produce a pulse until it is released and pressed again.
  localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int AW         = cnt_width(ARM_CYCLES);

  logic inc_sync, inc_level, inc_flip;
  logic load_sync, load_level, load_flip;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_inc),
    .sync  (inc_sync),
    .level (inc_level),
    .flip  (inc_flip)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_load),
    .sync  (load_sync),
    .level (load_level),
    .flip  (load_flip)
  );

  logic          inc_armed, load_armed;
  logic [AW-1:0] inc_arm_cnt, load_arm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_armed    <= 1'b0;
      inc_arm_cnt  <= '0;
      load_armed   <= 1'b0;
      load_arm_cnt <= '0;
    end else begin
      if (!inc_armed) begin
        if (inc_sync)                              inc_arm_cnt <= '0;
        else if (inc_arm_cnt == AW'(ARM_CYCLES))   inc_armed   <= 1'b1;
        else                                       inc_arm_cnt <= inc_arm_cnt + AW'(1);
      end
      if (!load_armed) begin
        if (load_sync)                             load_arm_cnt <= '0;
        else if (load_arm_cnt == AW'(ARM_CYCLES))  load_armed   <= 1'b1;
        else                                       load_arm_cnt <= load_arm_cnt + AW'(1);
      end
    end
  end

  // Edge events, taken on the same edge the debounced level changes.
  logic inc_rise, inc_fall, load_rise;

  assign inc_rise  = inc_flip & ~inc_level & inc_armed;
  assign inc_fall  = inc_flip & inc_level;
  assign load_rise = load_flip & ~load_level & load_armed;

  inc_state_t    state, state_n;
  logic [TW-1:0] timer, timer_n, timer_inc;
  logic          fire;
  logic          pending, pending_n;
  logic          inc_q, inc_n;
  logic          load_q, load_n;
  logic          inc_req;

  assign timer_inc = timer + TW'(1);

  always_comb begin
    state_n = state;
    timer_n = timer;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (inc_rise) begin
          fire    = 1'b1;
          timer_n = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (inc_fall) begin
          state_n = IDLE;
        end else if (REPEAT_DELAY > 0) begin
          if (timer_inc == TW'(REPEAT_DELAY)) begin
            fire    = 1'b1;
            timer_n = '0;
            state_n = REPEAT;
          end else begin
            timer_n = timer_inc;
          end
        end
      end
      REPEAT: begin
        if (inc_fall) begin
          state_n = IDLE;
        end else if (timer_inc == TW'(REPEAT_PERIOD)) begin
          fire    = 1'b1;
          timer_n = '0;
        end else begin
          timer_n = timer_inc;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!ena) begin
      state_n = IDLE;
      timer_n = '0;
      fire    = 1'b0;
    end
  end

  // Arbitration: a load takes the cycle and any increment waits one cycle.
  // When a deferred increment goes out on a cycle that also fires, the new
  // one becomes the single pending pulse.
  always_comb begin
    inc_req   = fire | pending;
    load_n    = ena & load_rise;
    inc_n     = 1'b0;
    pending_n = 1'b0;
    if (load_n) begin
      pending_n = inc_req;
    end else begin
      inc_n     = inc_req;
      pending_n = pending & fire;
    end
    if (!ena) begin
      inc_n     = 1'b0;
      pending_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      pending   <= 1'b0;
      inc_q     <= 1'b0;
      load_q    <= 1'b0;
      load_data <= 8'h00;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      pending <= pending_n;
      inc_q   <= inc_n;
      load_q  <= load_n;
      if (load_n) load_data <= load_value;
    end
  end

  assign inc_pulse  = inc_q & ena;
  assign load_pulse = load_q & ena;

endmodule

// File: tb/tb_count_input_conditioner.sv
// Testbench for count_input_conditioner (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3). Inputs change on the falling edge; "edge c" is the c-th
// rising edge after a scenario starts, and outputs are sampled on the
// falling edge that follows it.
module tb_count_input_conditioner;
  import count_input_conditioner_pkg::*;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  localparam int NR = 1500;

  logic       clk = 1'b0;
  logic       rst, ena, raw_inc, raw_load;
  logic [7:0] load_value;
  logic       inc_pulse, load_pulse;
  logic [7:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  bit       rinc_h [NR];
  bit       rload_h[NR];
  bit       ena_h  [NR];
  bit [7:0] val_h  [NR];

  count_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .raw_inc   (raw_inc),
    .raw_load  (raw_load),
    .load_value(load_value),
    .inc_pulse (inc_pulse),
    .load_pulse(load_pulse),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    raw_inc  = 1'b0;
    raw_load = 1'b0;
    ena      = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; raw_inc = 1'b0; raw_load = 1'b0; load_value = 8'hFF;
    repeat (2) @(negedge clk);
    n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_inc: got %b want 0", inc_pulse); end
    n_checks++; if (load_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", load_pulse); end
    n_checks++; if (load_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", load_data); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
    rst = 1'b0;
    idle(20);
  endtask

  task automatic test_single_press();
    bit exp;
    for (int c = 0; c < 20; c++) begin
      raw_inc = (c < 5);
      @(posedge clk); @(negedge clk);
      exp = (c == 6);
      n_checks++; if (inc_pulse !== exp) begin n_fail++; $display("FAIL single_inc c=%0d: got %b want %b", c, inc_pulse, exp); end
      n_checks++; if (load_pulse !== 1'b0) begin n_fail++; $display("FAIL single_load c=%0d: got %b want 0", c, load_pulse); end
      if (c == 5 || c == 6) begin
        exp = (c == 6);
        n_checks++; if (dut.u_inc_db.level !== exp) begin n_fail++; $display("FAIL single_level c=%0d: got %b want %b", c, dut.u_inc_db.level, exp); end
      end
    end
    idle(20);
  endtask

  task automatic test_glitch();
    for (int c = 0; c < 20; c++) begin
      raw_inc = (c < 3);
      @(posedge clk); @(negedge clk);
      n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL glitch_inc c=%0d: got %b want 0", c, inc_pulse); end
      n_checks++; if (dut.u_inc_db.level !== 1'b0) begin n_fail++; $display("FAIL glitch_level c=%0d: got %b want 0", c, dut.u_inc_db.level); end
    end
    idle(20);
  endtask

  task automatic test_hold_repeat();
    bit exp;
    for (int c = 0; c < 60; c++) begin
      raw_inc = (c < 40);
      @(posedge clk); @(negedge clk);
      exp = (c == 6) || (c >= 14 && c < 46 && ((c - 14) % 3) == 0);
      n_checks++; if (inc_pulse !== exp) begin n_fail++; $display("FAIL repeat_inc c=%0d: got %b want %b", c, inc_pulse, exp); end
    end
    idle(20);
  endtask

  task automatic test_load();
    bit exp;
    for (int c = 0; c < 30; c++) begin
      raw_load   = (c < 6);
      load_value = (c < 8) ? 8'hA5 : 8'h3C;
      @(posedge clk); @(negedge clk);
      exp = (c == 6);
      n_checks++; if (load_pulse !== exp) begin n_fail++; $display("FAIL load_pulse c=%0d: got %b want %b", c, load_pulse, exp); end
      n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL load_inc c=%0d: got %b want 0", c, inc_pulse); end
      if (c == 6 || c == 26) begin
        n_checks++; if (load_data !== 8'hA5) begin n_fail++; $display("FAIL load_data c=%0d: got %h want a5", c, load_data); end
      end
    end
    idle(20);
  endtask

  task automatic test_back_to_back();
    bit ei, el;
    for (int c = 0; c < 30; c++) begin
      raw_inc    = (c < 12);
      raw_load   = (c < 6);
      load_value = 8'h5A;
      @(posedge clk); @(negedge clk);
      ei = (c == 7) || (c == 14) || (c == 17);
      el = (c == 6);
      n_checks++; if (inc_pulse !== ei) begin n_fail++; $display("FAIL b2b_inc c=%0d: got %b want %b", c, inc_pulse, ei); end
      n_checks++; if (load_pulse !== el) begin n_fail++; $display("FAIL b2b_load c=%0d: got %b want %b", c, load_pulse, el); end
      n_checks++; if (inc_pulse && load_pulse) begin n_fail++; $display("FAIL b2b_both c=%0d: got both high want exclusive", c); end
    end
    n_checks++; if (load_data !== 8'h5A) begin n_fail++; $display("FAIL b2b_data: got %h want 5a", load_data); end
    idle(20);
  endtask

  task automatic test_enable();
    bit exp;
    // Press and debounce while disabled, enable while still held: no pulse.
    for (int c = 0; c < 24; c++) begin
      ena      = (c >= 8);
      raw_inc  = (c < 14);
      raw_load = (c < 6);
      @(posedge clk); @(negedge clk);
      n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL ena_inc c=%0d: got %b want 0", c, inc_pulse); end
      n_checks++; if (load_pulse !== 1'b0) begin n_fail++; $display("FAIL ena_load c=%0d: got %b want 0", c, load_pulse); end
    end
    idle(20);
    for (int c = 0; c < 12; c++) begin
      raw_inc = (c < 5);
      @(posedge clk); @(negedge clk);
      exp = (c == 6);
      n_checks++; if (inc_pulse !== exp) begin n_fail++; $display("FAIL ena_repress c=%0d: got %b want %b", c, inc_pulse, exp); end
    end
    idle(20);
  endtask

  task automatic test_reset_mid_press();
    bit exp;
    bit saw;
    saw = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      raw_inc = 1'b1;
      @(posedge clk); @(negedge clk);
      if (c == 20) saw = inc_pulse;
    end
    n_checks++; if (saw !== 1'b1) begin n_fail++; $display("FAIL midrst_prepulse: got %b want 1", saw); end
    rst = 1'b1;
    #1;
    n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_inc: got %b want 0", inc_pulse); end
    n_checks++; if (load_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_load: got %b want 0", load_pulse); end
    n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d want IDLE", dut.state); end
    n_checks++; if (load_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", load_data); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      raw_inc = (c < 40);
      @(posedge clk); @(negedge clk);
      n_checks++; if (inc_pulse !== 1'b0) begin n_fail++; $display("FAIL midrst_held c=%0d: got %b want 0", c, inc_pulse); end
    end
    for (int c = 0; c < 14; c++) begin
      raw_inc = (c < 5);
      @(posedge clk); @(negedge clk);
      exp = (c == 6);
      n_checks++; if (inc_pulse !== exp) begin n_fail++; $display("FAIL midrst_repress c=%0d: got %b want %b", c, inc_pulse, exp); end
    end
    idle(20);
  endtask

  // Raw value of a channel as seen at edge i (0 before the scenario began).
  function automatic bit hist_at(input bit ch, input int i);
    if (i < 0) return 1'b0;
    return ch ? rload_h[i] : rinc_h[i];
  endfunction

  // A level flips at edge c when the D+1 raw samples that reach the
  // debouncer over that window all disagree with it.
  function automatic bit window_flip(input bit ch, input int c, input bit lvl);
    for (int k = 0; k <= D; k++)
      if (hist_at(ch, c - 2 - k) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_random();
    int  left_i, left_l, left_e;
    bit  cur_i, cur_l, cur_e;
    bit  lvl_i, lvl_l, fi, fl, rise_i, fall_i, rise_l;
    bit  fire, pend, ei, el;
    int  held, t;
    bit [7:0] ldata;
    left_i = 0; left_l = 0; left_e = 0;
    cur_i = 0; cur_l = 0; cur_e = 1;
    for (int c = 0; c < NR; c++) begin
      if (left_i == 0) begin
        cur_i  = ~cur_i;
        left_i = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 12);
      end
      if (left_l == 0) begin
        cur_l  = ~cur_l;
        left_l = $urandom_range(1, 16);
      end
      if (left_e == 0) begin
        cur_e  = ($urandom_range(0, 5) != 0);
        left_e = $urandom_range(5, 60);
      end
      left_i--; left_l--; left_e--;
      rinc_h[c] = cur_i; rload_h[c] = cur_l; ena_h[c] = cur_e;
      val_h[c]  = 8'($urandom);
    end
    lvl_i = 0; lvl_l = 0; held = -1; pend = 0; ldata = load_data;
    for (int c = 0; c < NR; c++) begin
      raw_inc = rinc_h[c]; raw_load = rload_h[c]; ena = ena_h[c]; load_value = val_h[c];
      @(posedge clk); @(negedge clk);
      fi = window_flip(1'b0, c, lvl_i);
      fl = window_flip(1'b1, c, lvl_l);
      rise_i = fi & ~lvl_i; fall_i = fi & lvl_i; rise_l = fl & ~lvl_l;
      if (fi) lvl_i = ~lvl_i;
      if (fl) lvl_l = ~lvl_l;
      ei = 0; el = 0; fire = 0;
      if (!ena_h[c]) begin
        held = -1; pend = 0;
      end else begin
        if (fall_i) held = -1;
        else if (rise_i) begin held = c; fire = 1; end
        else if (held >= 0) begin
          t = c - held;
          if (RD > 0 && (t == RD || (t > RD && ((t - RD) % RP) == 0))) fire = 1;
        end
        if (rise_l) begin
          el = 1; ldata = val_h[c]; pend = fire | pend;
        end else begin
          ei = fire | pend; pend = fire & pend;
        end
      end
      n_checks++; if (inc_pulse !== ei) begin n_fail++; $display("FAIL rand_inc c=%0d: got %b want %b", c, inc_pulse, ei); end
      n_checks++; if (load_pulse !== el) begin n_fail++; $display("FAIL rand_load c=%0d: got %b want %b", c, load_pulse, el); end
      n_checks++; if (load_data !== ldata) begin n_fail++; $display("FAIL rand_data c=%0d: got %h want %h", c, load_data, ldata); end
      n_checks++; if (inc_pulse && load_pulse) begin n_fail++; $display("FAIL rand_both c=%0d: got both high want exclusive", c); end
    end
    idle(20);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; raw_inc = 1'b0; raw_load = 1'b0; load_value = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_glitch();
    test_hold_repeat();
    test_load();
    test_back_to_back();
    test_enable();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_input_conditioner.md
COUNT_INPUT_CONDITIONER -- requirements
Module: count_input_conditioner

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  DEBOUNCE_CYCLES  16  consecutive synchronized cycles a new input level must hold before it is accepted (>=1).
  REPEAT_DELAY     64  cycles from the first inc pulse to the first auto-repeat pulse; 0 disables auto-repeat.
  REPEAT_PERIOD    16  cycles between subsequent auto-repeat pulses (>=1).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk         in   1  single clock; all state on its rising edge.
  rst         in   1  asynchronous, active-high reset.
  ena         in   1  enable; low suppresses all output pulses.
  raw_inc     in   1  asynchronous increment button.
  raw_load    in   1  asynchronous load button.
  load_value  in   8  value to load; held stable by the user while raw_load is pressed.
  inc_pulse   out  1  one-cycle increment strobe to the downstream counter's enable input.
  load_pulse  out  1  one-cycle load strobe to the downstream counter's load input.
  load_data   out  8  registered load value, valid while load_pulse is high.

Function
REQ-003 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 Each channel SHALL hold a debounced level that flips only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the run counter.
REQ-005 Latency SHALL be exactly 2+DEBOUNCE_CYCLES rising edges, counted from the first edge that samples a new stable raw level, to the cycle where the debounced level flips.
REQ-006 load_pulse SHALL be high for exactly one cycle, in the cycle the debounced load level rises; falls produce no pulse.
REQ-007 load_data SHALL capture load_value on the same edge that asserts load_pulse and SHALL hold it until the next load.
REQ-008 The inc channel SHALL use a 3-state FSM:
  - IDLE: on a debounced rise, emit a pulse, clear the timer, go to HOLD.
  - HOLD: if REPEAT_DELAY>0 and the timer reaches REPEAT_DELAY, emit a pulse, clear the timer, go to REPEAT.
  - REPEAT: emit a pulse each time the timer reaches REPEAT_PERIOD, then clear it.
REQ-009 A debounced inc fall SHALL return the FSM to IDLE from any state, with no pulse emitted in that cycle.
REQ-010 When REPEAT_DELAY=0, the FSM SHALL remain in HOLD until release, emitting no further pulses.
REQ-011 If an inc pulse and a load pulse fall in the same cycle, load_pulse SHALL assert and the inc pulse SHALL be deferred by exactly one cycle.
REQ-012 At most one inc pulse SHALL be pending; the FSM timing SHALL not be shifted by a deferral.
REQ-013 inc_pulse and load_pulse SHALL never be high in the same cycle.
REQ-014 While ena is low:
  - outputs SHALL be 0;
  - the FSM SHALL be forced to IDLE and any pending inc SHALL be dropped;
  - the synchronizers and debouncers SHALL keep running.
REQ-015 If ena rises while inc is already debounced high, no pulse SHALL be emitted until release and a new press.
REQ-016 The timer width SHALL be sized from max(REPEAT_DELAY, REPEAT_PERIOD) and SHALL never wrap while in HOLD or REPEAT.

Reset
REQ-017 Asserting rst SHALL immediately clear, asynchronously:
  - synchronizers, debounced levels and run counters;
  - FSM (to IDLE), timer and pending flag;
  - inc_pulse, load_pulse, and load_data (to 8'h00).
REQ-018 A reset asserted mid-press SHALL require release and a fresh debounced press before any further pulse.

Structure
REQ-019 A shared package SHALL hold the parameter defaults and the inc FSM state enum (IDLE, HOLD, REPEAT).
REQ-020 Synchronizer plus debouncer SHALL form one sub-module, input_debouncer, instantiated once per button; edge detection, the FSM and arbitration SHALL live in the top.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-021 The bench SHALL cover these directed scenarios:
  - raw_inc high at edge 0 and held for 5 cycles, then low -> single inc_pulse, debounced rise at edge 6, no repeat.
  - raw_inc glitch high for 3 cycles (<4) -> no pulse, debounced level unchanged.
  - raw_inc held 40 cycles -> first pulse at edge 6, then edges 14, 17, 20, ...; stops within 6 cycles of release.
  - raw_load with load_value=8'hA5 -> one load_pulse with load_data=8'hA5; load_data still 8'hA5 20 cycles later.
  - inc and load debounced on the same edge -> load_pulse at cycle N, inc_pulse at N+1, never both high together.
  - rst asserted mid-repeat -> outputs 0 immediately, FSM IDLE; held button yields no pulse until release and re-press.
